// File: rtl/mm_seq_ctrl.sv
// Job sequencer for the NxN systolic matmul array: clear, skewed edge feed, drain, capture, then hold the result.
// Result valid 3N-1+LAT edges after acceptance (one fewer when accumulating); i_en low stalls FEED/DRAIN; the result holds until i_out_ready.
module mm_seq_ctrl #(
  parameter int W   = 16,
  parameter int N   = 3,
  parameter int LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic               i_acc,
  input  logic [W*N*N-1:0]   i_A,
  input  logic [W*N*N-1:0]   i_B,
  output logic               o_arr_clr,
  output logic               o_arr_en,
  output logic [W*N-1:0]     o_a_row,
  output logic [W*N-1:0]     o_b_col,
  input  logic [W*N*N-1:0]   i_arr_C,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [W*N*N-1:0]   o_C,
  output logic               o_busy
);

  localparam int KMAX = (2*N-2 > N-2+LAT) ? 2*N-2 : N-2+LAT;
  localparam int KW   = (KMAX > 0) ? $clog2(KMAX+1) : 1;
  localparam logic [KW-1:0] FEED_LAST  = KW'(2*N-2);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(N-2+LAT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state;
  logic [KW-1:0]      k;
  logic [W*N*N-1:0]   a_q;
  logic [W*N*N-1:0]   b_q;
  logic [W*N-1:0]     a_nxt;
  logic [W*N-1:0]     b_nxt;

  assign o_in_ready = (state == S_IDLE);
  assign o_busy     = (state != S_IDLE);

  // Lane i carries A[i][k-i] and B[k-i][i]; outside the diagonal band it is zero.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(k) >= i && int'(k) - i < N) begin
        a_nxt[i*W +: W] = a_q[(N*N-1-(i*N+int'(k)-i))*W +: W];
        b_nxt[i*W +: W] = b_q[(N*N-1-((int'(k)-i)*N+i))*W +: W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      k           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      o_arr_clr   <= 1'b0;
      o_arr_en    <= 1'b0;
      o_a_row     <= '0;
      o_b_col     <= '0;
      o_out_valid <= 1'b0;
      o_C         <= '0;
    end else begin
      o_arr_clr <= 1'b0;
      o_arr_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_in_valid) begin
            a_q       <= i_A;
            b_q       <= i_B;
            k         <= '0;
            o_arr_clr <= !i_acc;
            state     <= i_acc ? S_FEED : S_CLEAR;
          end
        end
        S_CLEAR: begin
          k     <= '0;
          state <= S_FEED;
        end
        S_FEED: begin
          if (i_en) begin
            o_arr_en <= 1'b1;
            o_a_row  <= a_nxt;
            o_b_col  <= b_nxt;
            if (k == FEED_LAST) begin
              k     <= '0;
              state <= S_DRAIN;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (i_en) begin
            o_arr_en <= 1'b1;
            o_a_row  <= '0;
            o_b_col  <= '0;
            if (k == DRAIN_LAST) begin
              k           <= '0;
              o_C         <= i_arr_C;
              o_out_valid <= 1'b1;
              state       <= S_DONE;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl (N=3, LAT=1): reset, skew, latency, stall, accumulate, backpressure.
module tb_mm_seq_ctrl;

  localparam int W   = 16;
  localparam int N   = 3;
  localparam int LAT = 1;
  localparam int MW  = W*N*N;
  localparam int RW  = W*N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          acc = 1'b0;
  logic [MW-1:0] mat_a = '0;
  logic [MW-1:0] mat_b = '0;
  logic          arr_clr;
  logic          arr_en;
  logic [RW-1:0] a_row;
  logic [RW-1:0] b_col;
  logic [MW-1:0] arr_c = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MW-1:0] c_out;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [RW-1:0] a_snap [40];
  logic [RW-1:0] b_snap [40];
  logic          en_snap [40];
  logic          clr_snap [40];

  mm_seq_ctrl #(.W(W), .N(N), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_acc(acc), .i_A(mat_a), .i_B(mat_b), .o_arr_clr(arr_clr), .o_arr_en(arr_en),
    .o_a_row(a_row), .o_b_col(b_col), .i_arr_C(arr_c), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_C(c_out), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int r, input int c);
    return m[(N*N-1-(r*N+c))*W +: W];
  endfunction

  function automatic logic [MW-1:0] mk(input logic [W-1:0] base);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[(N*N-1-(r*N+c))*W +: W] = base + W'(r*16 + c);
    return m;
  endfunction

  // Integer MAC model of the array: c0 + a*b, element-wise mod 2^W.
  function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                           input logic [MW-1:0] c0);
    logic [MW-1:0] res;
    logic [W-1:0]  s;
    res = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = el(c0, r, c);
        for (int m = 0; m < N; m++) s = s + el(a, r, m) * el(b, m, c);
        res[(N*N-1-(r*N+c))*W +: W] = s;
      end
    return res;
  endfunction

  // Offers one job, scrambles the inputs after acceptance, and steps until o_out_valid (bounded).
  task automatic run_job(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic acc_i,
                         input int stall_at, input int stall_len, output int lat, output int clr_cnt);
    mat_a = a; mat_b = b; acc = acc_i; in_valid = 1'b1;
    step();
    in_valid = 1'b0; mat_a = ~a; mat_b = ~b; acc = ~acc_i;
    lat = -1;
    clr_cnt = 0;
    for (int cyc = 0; cyc < 40 && lat < 0; cyc++) begin
      if (cyc > 0) step();
      a_snap[cyc]   = a_row;
      b_snap[cyc]   = b_col;
      en_snap[cyc]  = arr_en;
      clr_snap[cyc] = arr_clr;
      if (arr_clr) clr_cnt++;
      if (out_valid) lat = cyc;
      if (cyc == stall_at) en = 1'b0;
      if (cyc == stall_at + stall_len) en = 1'b1;
    end
    en = 1'b1;
  endtask

  logic [MW-1:0] ask, bsk, a3, exp_c, exp_c3;
  int lat, clr_cnt;

  initial begin
    ask = mk(16'h1000);
    bsk = mk(16'h2000);
    a3  = '0;
    for (int r = 0; r < N; r++) a3[(N*N-1-(r*N+2))*W +: W] = 16'h3c00;

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    check("por_in_ready", MW'(in_ready), MW'(1));
    check("por_busy", MW'(busy), MW'(0));
    check("por_out_valid", MW'(out_valid), MW'(0));
    check("por_c", c_out, '0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Reset asserted mid-FEED takes effect without a clock edge
    mat_a = ask; mat_b = bsk; acc = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check("pre_rst_arr_en", MW'(arr_en), MW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_arr_en", MW'(arr_en), MW'(0));
    check("rst_a_row", MW'(a_row), '0);
    check("rst_b_col", MW'(b_col), '0);
    check("rst_arr_clr", MW'(arr_clr), MW'(0));
    check("rst_out_valid", MW'(out_valid), MW'(0));
    check("rst_in_ready", MW'(in_ready), MW'(1));
    check("rst_busy", MW'(busy), MW'(0));
    @(negedge clk) rst_n = 1'b1;
    step();
    check("post_rst_in_ready", MW'(in_ready), MW'(1));
    check("post_rst_busy", MW'(busy), MW'(0));
    check("post_rst_out_valid", MW'(out_valid), MW'(0));

    // Skew, latency and capture with the accumulators cleared
    out_ready = 1'b1;
    exp_c = matmul(ask, bsk, '0);
    arr_c = exp_c;
    run_job(ask, bsk, 1'b0, -1, 0, lat, clr_cnt);
    check("skew_k2_a", MW'(a_snap[4]), MW'(48'h1020_1011_1002));
    check("skew_k2_b", MW'(b_snap[4]), MW'(48'h2002_2011_2020));
    check("skew_k4_a", MW'(a_snap[6]), MW'(48'h1022_0000_0000));
    check("skew_k4_b", MW'(b_snap[6]), MW'(48'h2022_0000_0000));
    check("lat_plain", MW'(lat), MW'(9));
    check("clr_first", MW'(clr_snap[0]), MW'(1));
    check("clr_count", MW'(clr_cnt), MW'(1));
    check("capture_plain", c_out, exp_c);
    step();
    check("done_one_cycle", MW'(out_valid), MW'(0));
    check("idle_in_ready", MW'(in_ready), MW'(1));

    // Three-cycle stall at FEED k=1
    run_job(ask, bsk, 1'b0, 2, 3, lat, clr_cnt);
    check("stall_pre_en", MW'(en_snap[2]), MW'(1));
    for (int c = 3; c <= 5; c++) begin
      check("stall_en", MW'(en_snap[c]), MW'(0));
      check("stall_a_hold", MW'(a_snap[c]), MW'(48'h0000_0000_1000));
      check("stall_b_hold", MW'(b_snap[c]), MW'(48'h0000_0000_2000));
    end
    check("stall_resume_a", MW'(a_snap[6]), MW'(48'h0000_1010_1001));
    check("lat_stall", MW'(lat), MW'(12));
    check("capture_stall", c_out, exp_c);
    step();

    // Back-to-back accumulate job: no clear, one cycle shorter
    exp_c3 = matmul(a3, bsk, exp_c);
    arr_c = exp_c3;
    run_job(a3, bsk, 1'b1, -1, 0, lat, clr_cnt);
    check("acc_clr_count", MW'(clr_cnt), MW'(0));
    check("acc_k2_a", MW'(a_snap[3]), MW'(48'h0000_0000_3c00));
    check("lat_acc", MW'(lat), MW'(8));
    check("capture_acc", c_out, exp_c3);
    step();

    // Output backpressure with a job pending
    out_ready = 1'b0;
    arr_c = exp_c;
    run_job(ask, bsk, 1'b0, -1, 0, lat, clr_cnt);
    check("lat_bp", MW'(lat), MW'(9));
    arr_c = '0;
    mat_a = bsk; mat_b = ask; acc = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", MW'(out_valid), MW'(1));
      check("bp_c_stable", c_out, exp_c);
      check("bp_in_ready", MW'(in_ready), MW'(0));
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", MW'(out_valid), MW'(0));
    check("bp_release_in_ready", MW'(in_ready), MW'(1));
    step();
    in_valid = 1'b0;
    check("pending_accept_in_ready", MW'(in_ready), MW'(0));
    check("pending_accept_clr", MW'(arr_clr), MW'(1));
    check("pending_accept_busy", MW'(busy), MW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
